// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: digit patterns (seg[6]=a .. seg[0]=g) and
// the nibble used for undecodable patterns.
package seven_seg_pkg;

  localparam logic [3:0] NIBBLE_ERR = 4'hF;

  localparam logic [6:0] SEG_PAT [10] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011   // 9
  };

  // Index of the set bit in a one-hot digit select; 0 if none is set.
  function automatic logic [1:0] onehot_index(input logic [3:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seven_seg_enc.sv
// Combinational segment-pattern to BCD decoder; bad flags any pattern that is
// not one of the ten digits.
module seven_seg_enc
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       bad
);

  always_comb begin
    digit = NIBBLE_ERR;
    bad   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG_PAT[i]) begin
        digit = 4'(i);
        bad   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Reconstructs a 4-digit BCD value by watching a multiplexed seven-segment
// display; each digit is captured once its pattern has been stable long enough.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  logic [6:0]  seg_q, seg_p;
  logic [3:0]  sel_q, sel_p;
  logic [3:0]  cnt, cnt_next;
  logic [3:0]  flags, flags_next;
  logic [15:0] shadow;
  logic        err_sh, err_next;

  logic        usable, same, capture, done;
  logic [3:0]  dec_digit;
  logic        dec_bad;
  logic [1:0]  idx;

  seven_seg_enc u_enc (
    .seg   (seg_q),
    .digit (dec_digit),
    .bad   (dec_bad)
  );

  assign usable  = $onehot(sel_q);
  assign same    = ({seg_q, sel_q} == {seg_p, sel_p});
  assign capture = usable && same && (cnt == CNT_MAX - 4'd1);
  assign done    = (flags == 4'hF);
  assign idx     = onehot_index(sel_q);

  always_comb begin
    cnt_next = 4'd0;
    if (usable) begin
      if (!same)
        cnt_next = 4'd1;
      else if (cnt < CNT_MAX)
        cnt_next = cnt + 4'd1;
      else
        cnt_next = cnt;
    end
  end

  // Completion clears first, so a capture in the completion cycle starts the next frame.
  always_comb begin
    flags_next = done ? 4'h0 : flags;
    err_next   = done ? 1'b0 : err_sh;
    if (capture) begin
      flags_next = flags_next | sel_q;
      err_next   = err_next | dec_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '0;
      sel_q       <= '0;
      seg_p       <= '0;
      sel_p       <= '0;
      cnt         <= '0;
      flags       <= '0;
      shadow      <= '0;
      err_sh      <= 1'b0;
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      seg_q       <= seg;
      sel_q       <= dig_sel;
      seg_p       <= seg_q;
      sel_p       <= sel_q;
      cnt         <= cnt_next;
      flags       <= flags_next;
      err_sh      <= err_next;
      frame_valid <= done;
      if (capture)
        shadow[4*idx +: 4] <= dec_digit;
      if (done) begin
        value     <= shadow;
        frame_err <= err_sh;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: a run-length reference model predicts
// each frame (value, error, arrival cycle); a monitor checks every frame_valid.
module tb_seven_seg_reader;

  localparam int S = 4;

  localparam logic [6:0] PAT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;

  always #5 clk = ~clk;

  seven_seg_reader #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .value       (value),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  typedef struct {
    logic [15:0] v;
    logic        e;
    int          c;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   nframes = 0;

  // reference model state
  int          run = 0;
  logic [10:0] prev = '0;
  logic [3:0]  m_flags = '0;
  logic [3:0]  m_nib [4] = '{default: 4'h0};
  logic        m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One input sample per rising edge; a digit is captured when a run of
  // identical one-hot samples first reaches length S.
  task automatic model_step();
    logic [10:0] cur;
    int          old;
    int          d;
    logic        found;
    logic [3:0]  nib;
    exp_t        e;
    if (rst) begin
      run = 0;
      prev = '0;
      m_flags = '0;
      m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    end else begin
      cur = {seg, dig_sel};
      old = run;
      if ($countones(dig_sel) != 1) run = 0;
      else if (cur != prev) run = 1;
      else if (run < S) run = run + 1;
      if ($countones(dig_sel) == 1 && cur == prev && old == S - 1) begin
        d = 0;
        for (int i = 0; i < 4; i++) if (dig_sel[i]) d = i;
        found = 1'b0;
        nib = 4'hF;
        for (int k = 0; k < 10; k++) if (seg == PAT[k]) begin found = 1'b1; nib = 4'(k); end
        m_nib[d] = nib;
        m_err = m_err | ~found;
        m_flags[d] = 1'b1;
        if (m_flags == 4'hF) begin
          e.v = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
          e.e = m_err;
          e.c = cyc + 2;
          expq.push_back(e);
          m_flags = '0;
          m_err = 1'b0;
        end
      end
      prev = cur;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_valid === 1'b1) begin
        nframes++;
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame: got frame_valid=1 value=%h expected no frame (cycle %0d)", value, cyc);
        end else begin
          e = expq.pop_front();
          check("frame_value", value, e.v);
          check("frame_err", frame_err, e.e);
          check("frame_cycle", cyc, e.c);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg = s;
    dig_sel = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int dig, input int val, input int n);
    hold(PAT[val], 4'(1 << dig), n);
  endtask

  task automatic idle(input int n);
    hold(7'b0, 4'b0, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    seg = '0;
    dig_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nf;
    logic [6:0] rs;
    logic [3:0] rd;
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("reset_value", value, 16'h0000);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_frame_valid", frame_valid, 1'b0);
    rst = 1'b0;

    // clean scan 1,2,3,4
    show(0, 1, 4); show(1, 2, 4); show(2, 3, 4); show(3, 4, 4); idle(4);
    check("scan_4321", value, 16'h4321);
    check("scan_4321_err", frame_err, 1'b0);

    // digit 0 re-captured: last value wins
    show(0, 5, 4); show(0, 7, 4); show(1, 8, 4); show(2, 8, 4); show(3, 8, 4); idle(4);
    check("recapture_8887", value, 16'h8887);

    // undecodable digit 1, then a clean frame
    show(0, 0, 4); hold(7'b0000001, 4'b0010, 4); show(2, 2, 4); show(3, 3, 4); idle(4);
    check("bad_digit_value", value, 16'h32F0);
    check("bad_digit_err", frame_err, 1'b1);
    show(0, 5, 4); show(1, 6, 4); show(2, 7, 4); show(3, 8, 4); idle(4);
    check("clean_after_bad", value, 16'h8765);
    check("clean_after_bad_err", frame_err, 1'b0);

    // one-cycle select glitches restart the window (frame_cycle checks the delay)
    show(0, 1, 4);
    show(1, 2, 2); hold(PAT[2], 4'b0011, 1); show(1, 2, 4);
    show(2, 3, 4);
    show(3, 4, 3); hold(PAT[4], 4'b0000, 1); show(3, 4, 4);
    idle(4);
    check("glitch_4321", value, 16'h4321);

    // reset after three captures
    show(0, 1, 4); show(1, 2, 4); show(2, 3, 4); idle(2);
    nf = nframes;
    do_reset();
    check("midframe_reset_value", value, 16'h0000);
    check("midframe_reset_err", frame_err, 1'b0);
    show(0, 9, 4); show(1, 8, 4); show(2, 7, 4); show(3, 6, 4); idle(4);
    check("post_reset_6789", value, 16'h6789);
    check("post_reset_one_frame", nframes, nf + 1);

    // digit 2 held one cycle short: no capture, no frame, value held
    nf = nframes;
    show(0, 0, 4); show(1, 1, 4); show(2, 4, S - 1); show(3, 9, 4); idle(6);
    check("short_hold_no_frame", nframes, nf);
    check("short_hold_value_held", value, 16'h6789);
    do_reset();

    // randomized scans
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 9) < 8) ? PAT[$urandom_range(0, 9)] : 7'($urandom);
      rd = ($urandom_range(0, 9) < 9) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      hold(rs, rd, $urandom_range(1, 6));
    end
    idle(6);
    check("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
